// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the modulo-N counter family.
//   MODE_WRAP / MODE_SAT : values for the counter's SATURATE parameter
//   clog2_min1()         : register width for a given modulus, never below 1
// ---------------------------------------------------------------------------
package contador_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // $clog2 gives 0 for a modulus of 1 and we still want a real register,
    // so the width is clamped to at least one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ffd_ar.sv
// ---------------------------------------------------------------------------
// ffd_ar
// WIDTH-bit D register with asynchronous active-low reset to zero.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   d   : next value
//   q   : registered value
// ---------------------------------------------------------------------------
module ffd_ar #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/contador_mod_n.sv
// ---------------------------------------------------------------------------
// contador_mod_n
// Parametrised modulo-N up/down counter with clear, parallel load,
// wrap/saturate mode and a combinational terminal-count output for
// cascading into multi-digit counters.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous reset, active-low (clears q and err)
//   en     : count enable
//   up     : 1 = increment, 0 = decrement
//   clr    : synchronous clear (highest priority)
//   ld     : synchronous parallel load of ld_val
//   ld_val : load value, rejected when >= MODULUS
//   q      : registered count, 0..MODULUS-1
//   tc     : terminal count, combinational from q, en and up
//   err    : one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module contador_mod_n
    import contador_pkg::*;
#(
    parameter int MODULUS  = 5,
    parameter int WIDTH    = clog2_min1(MODULUS),
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);

    // All comparisons and arithmetic use one extra bit so that MODULUS-1,
    // q+1 and an out-of-range ld_val are represented without overflow.
    localparam logic [WIDTH:0] LAST   = (WIDTH+1)'(MODULUS - 1);
    localparam bit             SAT_EN = (SATURATE == MODE_SAT);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   ld_ext;
    logic [WIDTH:0]   q_inc;
    logic [WIDTH:0]   q_dec;
    logic             at_last;
    logic             at_zero;
    logic             q_illegal;
    logic             ld_bad;
    logic [WIDTH-1:0] q_next;
    logic             err_next;

    assign q_ext     = {1'b0, q};
    assign ld_ext    = {1'b0, ld_val};
    assign q_inc     = q_ext + (WIDTH+1)'(1);
    assign q_dec     = q_ext - (WIDTH+1)'(1);
    assign at_last   = (q_ext == LAST);
    assign at_zero   = (q_ext == '0);
    assign q_illegal = (q_ext > LAST);
    assign ld_bad    = (ld_ext > LAST);

    // Terminal count is deliberately not gated by clr/ld: a downstream
    // stage applies the same priority itself and needs zero latency here.
    assign tc = en & ((up & at_last) | (~up & at_zero));

    // Next-state selection, priority clr > ld > (illegal recovery) > en.
    // An out-of-range q (only reachable by upsetting the register) is
    // pulled back to zero on the next edge that neither clears nor loads,
    // whether or not counting is enabled. The explicit end-of-range
    // compare is kept even when MODULUS is a power of two.
    always_comb begin
        q_next   = q;
        err_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (ld) begin
            if (ld_bad) begin
                err_next = 1'b1;
            end else begin
                q_next = ld_val;
            end
        end else if (q_illegal) begin
            q_next = '0;
        end else if (en) begin
            if (up) begin
                if (!at_last) begin
                    q_next = WIDTH'(q_inc);
                end else if (!SAT_EN) begin
                    q_next = '0;
                end
            end else begin
                if (!at_zero) begin
                    q_next = WIDTH'(q_dec);
                end else if (!SAT_EN) begin
                    q_next = WIDTH'(LAST);
                end
            end
        end
    end

    ffd_ar #(
        .WIDTH (WIDTH)
    ) u_q_reg (
        .clk (clk),
        .rst (rst),
        .d   (q_next),
        .q   (q)
    );

    ffd_ar #(
        .WIDTH (1)
    ) u_err_reg (
        .clk (clk),
        .rst (rst),
        .d   (err_next),
        .q   (err)
    );

endmodule

// File: tb/tb_contador_mod_n.sv
// ---------------------------------------------------------------------------
// tb_contador_mod_n
// Directed bench for contador_mod_n. Instances:
//   u_a  : MODULUS=5, wrap          (shares en/up with u_b)
//   u_b  : MODULUS=5, saturate
//   u_c  : MODULUS=10, load / clear / error / async reset
//   u_lo, u_hi : two MODULUS=10 stages cascaded through tc
//   u_d  : MODULUS=2,  u_e : MODULUS=16 (share en/up)
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_contador_mod_n;

    logic       clk = 1'b0;
    logic       rst;

    logic       en_a, up_a;
    logic [2:0] q_a, q_b;
    logic       tc_a, tc_b, err_a, err_b;

    logic       en_c, up_c, clr_c, ld_c;
    logic [3:0] ld_val_c, q_c;
    logic       tc_c, err_c;

    logic       en_lo;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, err_lo, err_hi;

    logic       en_d, up_d;
    logic [0:0] q_d;
    logic [3:0] q_e;
    logic       tc_d, tc_e, err_d, err_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    contador_mod_n #(.MODULUS(5), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .up(up_a), .clr(1'b0), .ld(1'b0),
        .ld_val(3'd0), .q(q_a), .tc(tc_a), .err(err_a));

    contador_mod_n #(.MODULUS(5), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .en(en_a), .up(up_a), .clr(1'b0), .ld(1'b0),
        .ld_val(3'd0), .q(q_b), .tc(tc_b), .err(err_b));

    contador_mod_n #(.MODULUS(10)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .up(up_c), .clr(clr_c), .ld(ld_c),
        .ld_val(ld_val_c), .q(q_c), .tc(tc_c), .err(err_c));

    contador_mod_n #(.MODULUS(10)) u_lo (
        .clk(clk), .rst(rst), .en(en_lo), .up(1'b1), .clr(1'b0), .ld(1'b0),
        .ld_val(4'd0), .q(q_lo), .tc(tc_lo), .err(err_lo));

    contador_mod_n #(.MODULUS(10)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .up(1'b1), .clr(1'b0), .ld(1'b0),
        .ld_val(4'd0), .q(q_hi), .tc(tc_hi), .err(err_hi));

    contador_mod_n #(.MODULUS(2)) u_d (
        .clk(clk), .rst(rst), .en(en_d), .up(up_d), .clr(1'b0), .ld(1'b0),
        .ld_val(1'b0), .q(q_d), .tc(tc_d), .err(err_d));

    contador_mod_n #(.MODULUS(16)) u_e (
        .clk(clk), .rst(rst), .en(en_d), .up(up_d), .clr(1'b0), .ld(1'b0),
        .ld_val(4'd0), .q(q_e), .tc(tc_e), .err(err_e));

    // Advance one clock and land 1 ns after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and counts/reports it when it differs.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse reset between edges, release it on a falling edge.
    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int t1[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        int t2[6]  = '{4, 3, 2, 1, 0, 4};
        int sat_b;
        int exp_d, exp_e, val;

        rst = 1'b0;
        en_a = 1'b0; up_a = 1'b1;
        en_c = 1'b0; up_c = 1'b1; clr_c = 1'b0; ld_c = 1'b0; ld_val_c = 4'd0;
        en_lo = 1'b0;
        en_d = 1'b0; up_d = 1'b1;

        // Reset state
        #2;
        checkOutput("rst_q_a", q_a, 0);
        checkOutput("rst_err_a", err_a, 0);
        checkOutput("rst_q_c", q_c, 0);
        checkOutput("rst_err_c", err_c, 0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: mod-5 up count, wrap and saturate side by side
        $display("[TB] mod-5 up count");
        en_a = 1'b1; up_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            sat_b = (i + 1 > 4) ? 4 : i + 1;
            checkOutput("up5_q", q_a, t1[i]);
            checkOutput("up5_tc", tc_a, (t1[i] == 4));
            checkOutput("up5_err", err_a, 0);
            checkOutput("sat5_up_q", q_b, sat_b);
            checkOutput("sat5_up_tc", tc_b, (sat_b == 4));
        end

        // Test 2: mod-5 down count from reset; saturating copy sticks at 0
        $display("[TB] mod-5 down count");
        up_a = 1'b0;
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("dn5_q", q_a, t2[i]);
            checkOutput("dn5_tc", tc_a, (t2[i] == 0));
            checkOutput("sat5_dn_q", q_b, 0);
            checkOutput("sat5_dn_tc", tc_b, 1);
        end
        en_a = 1'b0;

        // Test 3: load, rejected load, clear priority, load beats count
        $display("[TB] mod-10 load and error");
        ld_c = 1'b1; ld_val_c = 4'd7;
        applyStimulus();
        checkOutput("ld7_q", q_c, 7);
        checkOutput("ld7_err", err_c, 0);
        ld_val_c = 4'd12;
        applyStimulus();
        checkOutput("ld12_q", q_c, 7);
        checkOutput("ld12_err", err_c, 1);
        ld_c = 1'b0;
        applyStimulus();
        checkOutput("idle_q", q_c, 7);
        checkOutput("err_drop", err_c, 0);
        ld_c = 1'b1; ld_val_c = 4'd9;
        applyStimulus();
        checkOutput("ld9_q", q_c, 9);
        checkOutput("ld9_err", err_c, 0);
        ld_val_c = 4'd10;
        applyStimulus();
        checkOutput("ld10_q", q_c, 9);
        checkOutput("ld10_err", err_c, 1);
        clr_c = 1'b1; ld_val_c = 4'd12;
        applyStimulus();
        checkOutput("clr_ld_q", q_c, 0);
        checkOutput("clr_ld_err", err_c, 0);
        clr_c = 1'b0; ld_val_c = 4'd3; en_c = 1'b1; up_c = 1'b1;
        applyStimulus();
        checkOutput("ld_en_q", q_c, 3);
        ld_c = 1'b0;
        applyStimulus();
        checkOutput("cnt_after_ld", q_c, 4);

        // Test 4: asynchronous reset between edges
        $display("[TB] async reset");
        en_c = 1'b0; ld_c = 1'b1; ld_val_c = 4'd3;
        applyStimulus();
        checkOutput("pre_rst_q", q_c, 3);
        ld_val_c = 4'd15;
        applyStimulus();
        checkOutput("pre_rst_err", err_c, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_q", q_c, 0);
        checkOutput("async_err", err_c, 0);
        @(negedge clk);
        rst = 1'b1;
        ld_c = 1'b0; en_c = 1'b1; up_c = 1'b1;
        applyStimulus();
        checkOutput("post_rst_q", q_c, 1);
        en_c = 1'b0;

        // Test 5: two-digit cascade 00..99 and back to 00
        $display("[TB] cascade");
        doReset();
        en_lo = 1'b1;
        #1;
        checkOutput("casc_start", int'(q_hi) * 10 + int'(q_lo), 0);
        for (int i = 1; i <= 100; i++) begin
            applyStimulus();
            val = i % 100;
            checkOutput("casc_val", int'(q_hi) * 10 + int'(q_lo), val);
            checkOutput("casc_tc_hi", tc_hi, (val == 99));
        end
        checkOutput("casc_err", {30'd0, err_hi, err_lo}, 0);
        en_lo = 1'b0;

        // Test 6: power-of-two and minimum modulus, up then down, with idles
        $display("[TB] mod-2 / mod-16");
        doReset();
        exp_d = 0; exp_e = 0;
        up_d = 1'b1;
        for (int i = 0; i < 48; i++) begin
            en_d = !(i >= 20 && i < 24);
            applyStimulus();
            if (en_d) begin
                exp_d = (exp_d + 1) % 2;
                exp_e = (exp_e + 1) % 16;
            end
            checkOutput("m2_up_q", q_d, exp_d);
            checkOutput("m16_up_q", q_e, exp_e);
            checkOutput("m16_up_tc", tc_e, (en_d && exp_e == 15));
        end
        up_d = 1'b0;
        for (int i = 0; i < 48; i++) begin
            en_d = !(i >= 7 && i < 12);
            applyStimulus();
            if (en_d) begin
                exp_d = (exp_d + 1) % 2;
                exp_e = (exp_e + 15) % 16;
            end
            checkOutput("m2_dn_q", q_d, exp_d);
            checkOutput("m2_dn_tc", tc_d, (en_d && exp_d == 0));
            checkOutput("m16_dn_q", q_e, exp_e);
            checkOutput("m16_dn_tc", tc_e, (en_d && exp_e == 0));
        end
        checkOutput("m16_err", {30'd0, err_e, err_d}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
